// File: rtl/instruction_decode.sv
// RV32I decode stage: field split, 32x32 register file with async reads and
// one write port, and opcode-keyed immediate generation.
module instruction_decode (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data,
   input  logic        WrEn,
   input  logic [31:0] DIn,
   output logic [6:0]  opcode,
   output logic [2:0]  f3,
   output logic [6:0]  f7,
   output logic [31:0] r1,
   output logic [31:0] r2,
   output logic [31:0] Imm
);

   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpSystem = 7'b1110011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;

   logic [4:0]  w_rd;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [31:0] r_regs [32];

   assign opcode = data[6:0];
   assign f3     = data[14:12];
   assign f7     = data[31:25];
   assign w_rd   = data[11:7];
   assign w_rs1  = data[19:15];
   assign w_rs2  = data[24:20];

   // Entry 0 is cleared by reset and never written; reads also force it to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= 32'd0;
         end
      end else if (WrEn && (w_rd != 5'd0)) begin
         r_regs[w_rd] <= DIn;
      end
   end

   assign r1 = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
   assign r2 = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

   always_comb begin
      Imm = 32'd0;
      case (opcode)
         OpImm, OpLoad, OpJalr, OpSystem:
            Imm = {{20{data[31]}}, data[31:20]};
         OpStore:
            Imm = {{20{data[31]}}, data[31:25], data[11:7]};
         OpBranch:
            Imm = {{19{data[31]}}, data[31], data[7], data[30:25], data[11:8], 1'b0};
         OpLui, OpAuipc:
            Imm = {data[31:12], 12'd0};
         OpJal:
            Imm = {{11{data[31]}}, data[31], data[19:12], data[20], data[30:21], 1'b0};
         default:
            Imm = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed scenarios plus random
// instruction/write traffic against an array-based register model.
module tb_instruction_decode;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data;
   logic        WrEn;
   logic [31:0] DIn;
   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] r1;
   logic [31:0] r2;
   logic [31:0] Imm;

   int checks = 0;
   int errors = 0;
   logic [31:0] model [32];

   instruction_decode dut (
      .clk    (clk),
      .rst    (rst),
      .data   (data),
      .WrEn   (WrEn),
      .DIn    (DIn),
      .opcode (opcode),
      .f3     (f3),
      .f7     (f7),
      .r1     (r1),
      .r2     (r2),
      .Imm    (Imm)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk_r(input int rd, input int rs1, input int rs2);
      return (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h33;
   endfunction

   // Immediate by format, built from field values with plain arithmetic.
   function automatic logic [31:0] ref_imm(input logic [31:0] d);
      int sgn;
      sgn = ($signed(d) < 0) ? -1 : 0;
      case (d[6:0])
         7'h13, 7'h03, 7'h67, 7'h73: return 32'($signed(d) >>> 20);
         7'h23: return 32'(($signed(d) >>> 25) * 32 + int'(d[11:7]));
         7'h63: return 32'(sgn * 4096 + int'(d[7]) * 2048 + int'(d[30:25]) * 32
                           + int'(d[11:8]) * 2);
         7'h37, 7'h17: return d & 32'hFFFF_F000;
         7'h6F: return 32'(sgn * 1048576 + int'(d[19:12]) * 4096 + int'(d[20]) * 2048
                           + int'(d[30:21]) * 2);
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] ref_reg(input int idx);
      return (idx == 0) ? 32'd0 : model[idx];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input int rd, input logic [31:0] v);
      data = mk_r(rd, 0, 0);
      WrEn = 1'b1;
      DIn  = v;
      tick();
      if (rd != 0) model[rd] = v;
      WrEn = 1'b0;
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      WrEn = 1'b0;
      DIn  = 32'd0;
      data = 32'd0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      for (int i = 0; i < 32; i++) begin
         data = mk_r(0, i, 31 - i);
         #1;
         checks++;
         if (r1 !== 32'd0 || r2 !== 32'd0) begin
            errors++;
            $display("FAIL reset_read idx=%0d r1=%h r2=%h expected 0", i, r1, r2);
         end
      end
   endtask

   task automatic test_field_decode();
      write_reg(9, 32'h1111_2222);
      write_reg(8, 32'h3333_4444);
      data = 32'h0084_8933;
      #1;
      checks++;
      if (opcode !== 7'h33 || f3 !== 3'd0 || f7 !== 7'd0 || Imm !== 32'd0) begin
         errors++;
         $display("FAIL add_fields opcode=%h f3=%h f7=%h Imm=%h expected 33/0/0/0",
                  opcode, f3, f7, Imm);
      end
      checks++;
      if (r1 !== 32'h1111_2222 || r2 !== 32'h3333_4444) begin
         errors++;
         $display("FAIL add_operands r1=%h r2=%h expected 11112222/33334444", r1, r2);
      end
   endtask

   task automatic test_write_read();
      data = 32'h0084_8933;
      WrEn = 1'b1;
      DIn  = 32'hDEAD_BEEF;
      tick();
      model[18] = 32'hDEAD_BEEF;
      WrEn = 1'b0;
      data = 32'h0009_0013;
      #1;
      checks++;
      if (r1 !== 32'hDEAD_BEEF || Imm !== 32'd0 || opcode !== 7'h13) begin
         errors++;
         $display("FAIL write_readback r1=%h Imm=%h opcode=%h expected deadbeef/0/13",
                  r1, Imm, opcode);
      end
   endtask

   task automatic test_sync_reset();
      // rd = rs1 = x18, so the pending write targets the register being observed
      data = 32'h0009_0913;
      rst  = 1'b1;
      WrEn = 1'b1;
      DIn  = 32'hCAFE_F00D;
      #1;
      checks++;
      if (r1 !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL reset_pre_edge r1=%h expected deadbeef", r1);
      end
      tick();
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      rst  = 1'b0;
      WrEn = 1'b0;
      data = 32'h0009_0013;
      #1;
      checks++;
      if (r1 !== 32'd0) begin
         errors++;
         $display("FAIL reset_post_edge r1=%h expected 0", r1);
      end
   endtask

   task automatic test_stype();
      write_reg(5, 32'h0000_1000);
      write_reg(24, 32'hA5A5_5A5A);
      data = 32'h0182_A223;
      #1;
      checks++;
      if (opcode !== 7'h23 || f3 !== 3'd2 || Imm !== 32'h4) begin
         errors++;
         $display("FAIL stype_fields opcode=%h f3=%h Imm=%h expected 23/2/4", opcode, f3, Imm);
      end
      checks++;
      if (r1 !== 32'h0000_1000 || r2 !== 32'hA5A5_5A5A) begin
         errors++;
         $display("FAIL stype_operands r1=%h r2=%h expected 1000/a5a55a5a", r1, r2);
      end
   endtask

   task automatic test_imm_formats();
      logic [31:0] words [4];
      logic [31:0] exp   [4];
      words = '{32'hFFF0_0093, 32'hFE00_0EE3, 32'h1234_5037, 32'h0080_006F};
      exp   = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h1234_5000, 32'h0000_0008};
      for (int i = 0; i < 4; i++) begin
         data = words[i];
         #1;
         checks++;
         if (Imm !== exp[i]) begin
            errors++;
            $display("FAIL imm_format data=%h Imm=%h expected %h", words[i], Imm, exp[i]);
         end
      end
   endtask

   task automatic test_x0();
      data = 32'h0000_0033;
      WrEn = 1'b1;
      DIn  = 32'h1234_5678;
      tick();
      WrEn = 1'b0;
      #1;
      checks++;
      if (r1 !== 32'd0 || r2 !== 32'd0) begin
         errors++;
         $display("FAIL x0_write r1=%h r2=%h expected 0", r1, r2);
      end
   endtask

   task automatic test_back_to_back();
      // Same-cycle read sees the old value; the new one appears after the edge.
      for (int k = 1; k < 32; k += 5) begin
         logic [31:0] v;
         v    = $urandom;
         data = mk_r(k, k, k);
         WrEn = 1'b1;
         DIn  = v;
         #1;
         checks++;
         if (r1 !== ref_reg(k)) begin
            errors++;
            $display("FAIL no_bypass x%0d r1=%h expected %h", k, r1, ref_reg(k));
         end
         tick();
         model[k] = v;
         WrEn = 1'b0;
         checks++;
         if (r1 !== v || r2 !== v) begin
            errors++;
            $display("FAIL b2b_visible x%0d r1=%h r2=%h expected %h", k, r1, r2, v);
         end
      end
   endtask

   task automatic test_random();
      logic [6:0] ops [10];
      ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
      for (int n = 0; n < 400; n++) begin
         logic [31:0] d;
         d = $urandom;
         if ($urandom_range(3) != 0) d[6:0] = ops[$urandom_range(9)];
         data = d;
         WrEn = 1'($urandom_range(1));
         DIn  = $urandom;
         rst  = ($urandom_range(63) == 0);
         #1;
         checks++;
         if (opcode !== d[6:0] || f3 !== d[14:12] || f7 !== d[31:25]
             || Imm !== ref_imm(d)) begin
            errors++;
            $display("FAIL rand_fields data=%h opcode=%h f3=%h f7=%h Imm=%h expected Imm %h",
                     d, opcode, f3, f7, Imm, ref_imm(d));
         end
         checks++;
         if (r1 !== ref_reg(int'(d[19:15])) || r2 !== ref_reg(int'(d[24:20]))) begin
            errors++;
            $display("FAIL rand_operands data=%h r1=%h r2=%h expected %h/%h", d, r1, r2,
                     ref_reg(int'(d[19:15])), ref_reg(int'(d[24:20])));
         end
         tick();
         if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
         end else if (WrEn && d[11:7] != 5'd0) begin
            model[d[11:7]] = DIn;
         end
      end
      rst  = 1'b0;
      WrEn = 1'b0;
   endtask

   initial begin
      rst  = 1'b0;
      WrEn = 1'b0;
      DIn  = 32'd0;
      data = 32'd0;
      tick();
      test_reset();
      test_field_decode();
      test_write_read();
      test_sync_reset();
      test_stype();
      test_imm_formats();
      test_x0();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
